multicycle_sequencer: RTL and testbench

MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

---
 rtl/multicycle_sequencer_pkg.sv | 23 ++
 rtl/seq_wait_timer.sv | 34 +++
 rtl/multicycle_sequencer.sv | 177 +++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_sequencer_pkg.sv
// Shared types for the multicycle instruction sequencer.
//   opcode_t : instruction opcode encodings recognised by the sequencer
//   state_t  : sequencer FSM states
package multicycle_sequencer_pkg;

    typedef enum logic [6:0] {
        LOAD   = 7'h03,
        STORE  = 7'h23,
        ARITH  = 7'h33,
        BRANCH = 7'h63
    } opcode_t;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    localparam int unsigned WAIT_W = 8;

endpackage

// File: rtl/seq_wait_timer.sv
// Memory-wait cycle counter for the sequencer.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart the count from zero (has priority over inc)
//   inc        : count one cycle spent waiting for an acknowledge
//   expired    : count has reached TIMEOUT_CYC
module seq_wait_timer
    import multicycle_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(TIMEOUT_CYC);

    logic [WAIT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == LIMIT);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle instruction sequencer: FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
//   clk, rst_n          : clock, asynchronous active-low reset
//   opcode              : opcode of the fetched instruction, latched in DECODE
//   alu_zero            : branch condition, selects the branch target
//   imem_ack, dmem_ack  : memory acknowledges (only honoured in FETCH / MEM)
//   imem_req, ir_we     : instruction fetch request / instruction-register load
//   dmem_req, dmem_we   : data access request / write qualifier
//   rf_we               : register-file write strobe
//   pc_we, pc_sel       : PC update strobe / source (1 = branch target)
//   bus_err, illegal    : sticky memory-timeout and unknown-opcode flags
//   retired             : count of completed instructions (wraps)
module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  opcode_t     opcode,
    input  logic        alu_zero,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    output logic        imem_req,
    output logic        ir_we,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        rf_we,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        bus_err,
    output logic        illegal,
    output logic [31:0] retired
);

    state_t      state, state_n;
    logic [6:0]  op_q;
    logic        expired;
    logic        cnt_inc;
    logic        cnt_clr;
    logic        retire;
    logic        set_bus_err;
    logic        set_illegal;

    logic imem_req_c, ir_we_c, dmem_req_c, dmem_we_c, rf_we_c, pc_we_c, pc_sel_c;

    seq_wait_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wait (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (cnt_clr),
        .inc     (cnt_inc),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FETCH;
            op_q    <= '0;
            retired <= '0;
            bus_err <= 1'b0;
            illegal <= 1'b0;
        end else begin
            state <= state_n;
            if (state == DECODE) begin
                op_q <= opcode;
            end
            if (retire) begin
                retired <= retired + 32'd1;
            end
            if (set_bus_err) begin
                bus_err <= 1'b1;
            end
            if (set_illegal) begin
                illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        state_n     = state;
        imem_req_c  = 1'b0;
        ir_we_c     = 1'b0;
        dmem_req_c  = 1'b0;
        dmem_we_c   = 1'b0;
        rf_we_c     = 1'b0;
        pc_we_c     = 1'b0;
        pc_sel_c    = 1'b0;
        retire      = 1'b0;
        set_bus_err = 1'b0;
        set_illegal = 1'b0;
        cnt_inc     = 1'b0;

        unique case (state)
            FETCH: begin
                imem_req_c = 1'b1;
                if (imem_ack) begin
                    // An ack on the timeout cycle still wins.
                    ir_we_c = 1'b1;
                    state_n = DECODE;
                end else if (expired) begin
                    imem_req_c  = 1'b0;
                    pc_we_c     = 1'b1;
                    set_bus_err = 1'b1;
                    state_n     = FETCH;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            DECODE: begin
                state_n = EXEC;
            end
            EXEC: begin
                case (op_q)
                    ARITH:       state_n = WB;
                    LOAD, STORE: state_n = MEM;
                    BRANCH: begin
                        pc_we_c  = 1'b1;
                        pc_sel_c = alu_zero;
                        retire   = 1'b1;
                        state_n  = FETCH;
                    end
                    default: begin
                        pc_we_c     = 1'b1;
                        set_illegal = 1'b1;
                        state_n     = FETCH;
                    end
                endcase
            end
            MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = (op_q == STORE);
                if (dmem_ack) begin
                    if (op_q == STORE) begin
                        pc_we_c = 1'b1;
                        retire  = 1'b1;
                        state_n = FETCH;
                    end else begin
                        state_n = WB;
                    end
                end else if (expired) begin
                    dmem_req_c  = 1'b0;
                    dmem_we_c   = 1'b0;
                    pc_we_c     = 1'b1;
                    set_bus_err = 1'b1;
                    state_n     = FETCH;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            WB: begin
                rf_we_c = 1'b1;
                pc_we_c = 1'b1;
                retire  = 1'b1;
                state_n = FETCH;
            end
            default: begin
                state_n = FETCH;
            end
        endcase
    end

    // A timeout re-enters FETCH without a state change, so it must restart
    // the wait count explicitly.
    assign cnt_clr = (state_n != state) || set_bus_err;

    // Outputs are gated by rst_n so requests drop the moment reset asserts,
    // not at the next clock edge.
    assign imem_req = rst_n & imem_req_c;
    assign ir_we    = rst_n & ir_we_c;
    assign dmem_req = rst_n & dmem_req_c;
    assign dmem_we  = rst_n & dmem_we_c;
    assign rf_we    = rst_n & rf_we_c;
    assign pc_we    = rst_n & pc_we_c;
    assign pc_sel   = rst_n & pc_sel_c;

endmodule

// File: tb/tb_multicycle_sequencer.sv
module tb_multicycle_sequencer;
    import multicycle_sequencer_pkg::*;

    logic        clk;
    logic        rst_n;
    opcode_t     opcode;
    logic        alu_zero;
    logic        imem_ack;
    logic        dmem_ack;
    logic        imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel;
    logic        bus_err, illegal;
    logic [31:0] retired;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Output vector bit positions: {imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel}
    localparam logic [6:0] IMR = 7'b1000000;
    localparam logic [6:0] IRW = 7'b0100000;
    localparam logic [6:0] DMR = 7'b0010000;
    localparam logic [6:0] DMW = 7'b0001000;
    localparam logic [6:0] RFW = 7'b0000100;
    localparam logic [6:0] PCW = 7'b0000010;
    localparam logic [6:0] PSL = 7'b0000001;

    logic [6:0] outs;
    assign outs = {imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel};

    multicycle_sequencer #(
        .TIMEOUT_CYC (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .opcode   (opcode),
        .alu_zero (alu_zero),
        .imem_ack (imem_ack),
        .dmem_ack (dmem_ack),
        .imem_req (imem_req),
        .ir_we    (ir_we),
        .dmem_req (dmem_req),
        .dmem_we  (dmem_we),
        .rf_we    (rf_we),
        .pc_we    (pc_we),
        .pc_sel   (pc_sel),
        .bus_err  (bus_err),
        .illegal  (illegal),
        .retired  (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle's inputs mid-cycle, then let the outputs settle.
    task automatic drive(input logic ia, input logic da, input logic az, input opcode_t op);
        @(negedge clk);
        imem_ack = ia;
        dmem_ack = da;
        alu_zero = az;
        opcode   = op;
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        imem_ack = 1'b0; dmem_ack = 1'b0; alu_zero = 1'b0; opcode = ARITH;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (outs !== 7'b0) begin errors++; $display("FAIL reset_outs got %b want %b", outs, 7'b0); end
        checks++;
        if ({bus_err, illegal, retired} !== 34'b0) begin
            errors++; $display("FAIL reset_state got be=%b il=%b ret=%0d want 0 0 0", bus_err, illegal, retired);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (outs !== IMR) begin errors++; $display("FAIL reset_release got %b want %b", outs, IMR); end
    endtask

    task automatic test_arith;
        logic [6:0] exp_t [4] = '{IMR | IRW, 7'b0, 7'b0, RFW | PCW};
        opcode_t    op_t  [4] = '{ARITH, ARITH, opcode_t'(7'h7F), LOAD};
        int unsigned rf_pulses = 0;
        for (int i = 0; i < 4; i++) begin
            drive(i == 0, 1'b0, 1'b0, op_t[i]);
            if (rf_we === 1'b1) rf_pulses++;
            checks++;
            if (outs !== exp_t[i]) begin errors++; $display("FAIL arith_cyc%0d got %b want %b", i + 1, outs, exp_t[i]); end
        end
        @(posedge clk); #1;
        checks++;
        if (retired !== 32'd1 || rf_pulses != 1 || outs !== IMR) begin
            errors++; $display("FAIL arith_done got ret=%0d rf=%0d outs=%b want 1 1 %b", retired, rf_pulses, outs, IMR);
        end
    endtask

    task automatic test_load_wait;
        // Ack cycles: imem in 1 (plus a stray one in MEM), dmem in 7 (plus a stray one in DECODE).
        logic [6:0] exp_t [8] = '{IMR | IRW, 7'b0, 7'b0, DMR, DMR, DMR, DMR, RFW | PCW};
        logic [7:0] ia_v = 8'b0001_0001;
        logic [7:0] da_v = 8'b0100_0010;
        for (int i = 0; i < 8; i++) begin
            drive(ia_v[i], da_v[i], 1'b0, LOAD);
            checks++;
            if (outs !== exp_t[i]) begin errors++; $display("FAIL load_cyc%0d got %b want %b", i + 1, outs, exp_t[i]); end
        end
        @(posedge clk); #1;
        checks++;
        if (retired !== 32'd2) begin errors++; $display("FAIL load_retired got %0d want 2", retired); end
    endtask

    task automatic test_branch;
        for (int k = 0; k < 2; k++) begin
            logic       az     = (k == 0);
            logic [6:0] exp_ex = az ? (PCW | PSL) : PCW;
            drive(1'b1, 1'b0, az, BRANCH);
            checks++;
            if (outs !== (IMR | IRW)) begin errors++; $display("FAIL br%0d_fetch got %b want %b", k, outs, IMR | IRW); end
            drive(1'b0, 1'b0, az, BRANCH);
            checks++;
            if (outs !== 7'b0) begin errors++; $display("FAIL br%0d_decode got %b want 0", k, outs); end
            drive(1'b0, 1'b0, az, BRANCH);
            checks++;
            if (outs !== exp_ex) begin errors++; $display("FAIL br%0d_exec got %b want %b", k, outs, exp_ex); end
            @(posedge clk); #1;
            checks++;
            if (outs !== IMR || retired !== 32'd3 + k) begin
                errors++; $display("FAIL br%0d_done got outs=%b ret=%0d want %b %0d", k, outs, retired, IMR, 3 + k);
            end
        end
    endtask

    task automatic test_store_ack_on_timeout;
        // dmem_ack arrives exactly when the wait count hits TIMEOUT_CYC=4.
        logic [6:0] exp_t [8] = '{IMR | IRW, 7'b0, 7'b0, DMR | DMW, DMR | DMW, DMR | DMW, DMR | DMW, DMR | DMW | PCW};
        for (int i = 0; i < 8; i++) begin
            drive(i == 0, i == 7, 1'b0, STORE);
            checks++;
            if (outs !== exp_t[i]) begin errors++; $display("FAIL store_cyc%0d got %b want %b", i + 1, outs, exp_t[i]); end
        end
        @(posedge clk); #1;
        checks++;
        if (retired !== 32'd5 || bus_err !== 1'b0) begin
            errors++; $display("FAIL store_done got ret=%0d be=%b want 5 0", retired, bus_err);
        end
    endtask

    task automatic test_timeout;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b0, ARITH);
            checks++;
            if (outs !== ((i < 4) ? IMR : PCW)) begin
                errors++; $display("FAIL timeout_cyc%0d got %b want %b", i + 1, outs, (i < 4) ? IMR : PCW);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (bus_err !== 1'b1 || retired !== 32'd5 || outs !== IMR) begin
            errors++; $display("FAIL timeout_done got be=%b ret=%0d outs=%b want 1 5 %b", bus_err, retired, outs, IMR);
        end
    endtask

    task automatic test_illegal;
        logic [6:0] exp_t [3] = '{IMR | IRW, 7'b0, PCW};
        for (int i = 0; i < 3; i++) begin
            drive(i == 0, 1'b0, 1'b1, opcode_t'(7'h7F));
            checks++;
            if (outs !== exp_t[i]) begin errors++; $display("FAIL illegal_cyc%0d got %b want %b", i + 1, outs, exp_t[i]); end
        end
        @(posedge clk); #1;
        checks++;
        if (illegal !== 1'b1 || retired !== 32'd5) begin
            errors++; $display("FAIL illegal_flag got il=%b ret=%0d want 1 5", illegal, retired);
        end
        drive(1'b1, 1'b0, 1'b0, ARITH);
        drive(1'b0, 1'b0, 1'b0, ARITH);
        drive(1'b0, 1'b0, 1'b0, ARITH);
        drive(1'b0, 1'b0, 1'b0, ARITH);
        checks++;
        if (outs !== (RFW | PCW)) begin errors++; $display("FAIL illegal_next_wb got %b want %b", outs, RFW | PCW); end
        @(posedge clk); #1;
        checks++;
        if (retired !== 32'd6 || illegal !== 1'b1 || bus_err !== 1'b1) begin
            errors++; $display("FAIL sticky got ret=%0d il=%b be=%b want 6 1 1", retired, illegal, bus_err);
        end
    endtask

    task automatic test_reset_mid_store;
        drive(1'b1, 1'b0, 1'b0, STORE);
        drive(1'b0, 1'b0, 1'b0, STORE);
        drive(1'b0, 1'b0, 1'b0, STORE);
        drive(1'b0, 1'b0, 1'b0, STORE);
        checks++;
        if (outs !== (DMR | DMW)) begin errors++; $display("FAIL rst_mem_pre got %b want %b", outs, DMR | DMW); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs !== 7'b0 || retired !== 32'd0 || bus_err !== 1'b0 || illegal !== 1'b0) begin
            errors++; $display("FAIL rst_mem_async got outs=%b ret=%0d be=%b il=%b want 0 0 0 0", outs, retired, bus_err, illegal);
        end
        dmem_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (outs !== IMR) begin errors++; $display("FAIL rst_mem_release got %b want %b", outs, IMR); end
        @(posedge clk); #1;
        checks++;
        if (outs !== IMR || retired !== 32'd0) begin
            errors++; $display("FAIL rst_mem_fetch got outs=%b ret=%0d want %b 0", outs, retired, IMR);
        end
        dmem_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_arith();
        test_load_wait();
        test_branch();
        test_store_ack_on_timeout();
        test_timeout();
        test_illegal();
        test_reset_mid_store();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
